gemm_mem_responder: RTL and testbench
=====================================

Name: gemm_mem_responder

Overview:
Synthesizable AXI4-like memory responder (subordinate) for the accelerator's 256-bit DMA master port: accepts read/write address bursts, returns read beats and takes write beats from an internal word-addressed RAM. Used as on-chip result/operand memory in FPGA builds and as the memory endpoint in system simulation. Read and write channels are independent, with one outstanding transaction per channel.

Parameters:
DATA_WIDTH, 256, beat width in bits (fixed 32-byte beats)
ADDR_WIDTH, 32, byte address width
MEM_ADDR_WIDTH, 10, log2 of RAM depth in beats
READ_LATENCY, 2, wait cycles from AR handshake to first rvalid; legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_arvalid  in  1  read address valid
mem_araddr  in  ADDR_WIDTH  read burst byte address
mem_arlen  in  8  beats minus 1
mem_arsize  in  3  beat size; only 3'b101 is legal
mem_arready  out  1  read address accepted
mem_rvalid  out  1  read beat valid
mem_rdata  out  DATA_WIDTH  read beat data
mem_rlast  out  1  final read beat
mem_rready  in  1  master accepts read beat
mem_awvalid  in  1  write address valid
mem_awaddr  in  ADDR_WIDTH  write burst byte address
mem_awlen  in  8  beats minus 1
mem_awsize  in  3  beat size; only 3'b101 is legal
mem_awready  out  1  write address accepted
mem_wvalid  in  1  write beat valid
mem_wdata  in  DATA_WIDTH  write beat data
mem_wlast  in  1  master's last-beat marker
mem_wready  out  1  write beat accepted
mem_bvalid  out  1  write response valid
mem_bready  in  1  master accepts response
err_pulse  out  1  one-cycle protocol error strobe
busy  out  1  either channel not idle

Behaviour:
- Reset is synchronous active-low. While rst_n=0 all outputs are 0, both FSMs are idle, and counters clear. RAM contents are not reset.
- Word index = addr[MEM_ADDR_WIDTH+4:5]. Low 5 address bits are ignored. Each beat increments the index by 1, wrapping modulo 2^MEM_ADDR_WIDTH (INCR only).
- Read FSM:
  - R_IDLE: arready=1.
  - On arvalid&&arready: latch index and len, clear beat count, go to R_WAIT.
  - R_WAIT: count READ_LATENCY cycles, issue the synchronous RAM read of the first beat, then go to R_BURST.
  - With handshake on edge E0, rvalid is first high in the cycle after edge E0+READ_LATENCY.
  - R_BURST: rvalid=1, rlast = (count==len).
  - rdata/rlast stay stable while rvalid&&!rready.
  - On each rready handshake the next beat is prefetched, so back-to-back beats run at 1 beat/cycle.
  - On the last handshake go to R_IDLE; arready=1 again in the next cycle.
- Write FSM:
  - W_IDLE: awready=1.
  - On handshake: latch index and len, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready writes wdata at the current index.
  - The burst ends on the first beat where wlast=1 or count==len. Then go to W_RESP.
  - W_RESP: bvalid=1, held until bready. Then go to W_IDLE.
- err_pulse is high for one cycle on any of:
  - AR or AW handshake with size≠3'b101 (the transaction is still served);
  - burst end where wlast ≠ (count==len).
- Simultaneous read and write of the same word in the same cycle: read-first, so the read returns the old data.
- A channel handshake occurs only in the cycle both valid and ready are high. Inputs are ignored in all other states.
- Reset asserted mid-burst aborts both channels immediately; no rlast or bvalid is issued afterwards.
- busy = (read state≠R_IDLE) || (write state≠W_IDLE).

Decomposition:
- gemm_mem_pkg holds:
  - read/write state encodings (R_IDLE/R_WAIT/R_BURST, W_IDLE/W_DATA/W_RESP);
  - BEAT_BYTES=32;
  - SIZE_32B=3'b101.
- One sub-module, gemm_mem_ram_2p:
  - simple dual-port RAM, one write port and one synchronous read port;
  - read-first collision behaviour;
  - inferred as block RAM.

Test Plan:
- Preload word 4=0xA5..A5; AR addr=0x80, len=0 -> one beat 0xA5.., rlast=1, rvalid first high 3 cycles after handshake (READ_LATENCY=2).
- Write burst at addr 0x000, len=3, data 1,2,3,4 with wlast on beat 4 -> bvalid after beat 4, held 3 cycles until bready. Readback len=3 returns 1,2,3,4 with rlast only on beat 4.
- Read len=7 with rready toggling 1,0,0,1,... -> rdata stable during stalls, 8 beats in order, no beat dropped or duplicated.
- Write at last word (index 1023) with len=1 -> second beat lands at index 0, confirmed by readback.
- AW len=3 with wlast on beat 2 -> burst ends after 2 beats, err_pulse=1 for exactly one cycle, bvalid still issued. AR with arsize=3'b010 -> err_pulse, data still returned.
- rst_n low for 1 cycle mid read burst (beat 3 of 8) -> next cycle rvalid=0, busy=0. arready=1 one cycle after release, and a new AR is served correctly.

Source files
------------

// File: rtl/gemm_mem_pkg.sv
// Shared types and constants for the GEMM DMA memory responder.
package gemm_mem_pkg;

    localparam int unsigned BEAT_BYTES       = 32;
    localparam int unsigned BEAT_OFFSET_BITS = $clog2(BEAT_BYTES);
    localparam logic [2:0]  SIZE_32B         = 3'b101;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } rdState_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wrState_t;

endpackage

// File: rtl/gemm_mem_ram_2p.sv
// Simple dual-port beat RAM: one write port, one registered read port, read-first on collision.
module gemm_mem_ram_2p #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Non-blocking read and write in one process give old data on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gemm_mem_responder.sv
// AXI4-like burst memory subordinate for the 256-bit DMA port; independent read and write channels.
module gemm_mem_responder
    import gemm_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_arvalid,
    input  logic [ADDR_WIDTH-1:0] mem_araddr,
    input  logic [7:0]            mem_arlen,
    input  logic [2:0]            mem_arsize,
    output logic                  mem_arready,
    output logic                  mem_rvalid,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rlast,
    input  logic                  mem_rready,
    input  logic                  mem_awvalid,
    input  logic [ADDR_WIDTH-1:0] mem_awaddr,
    input  logic [7:0]            mem_awlen,
    input  logic [2:0]            mem_awsize,
    output logic                  mem_awready,
    input  logic                  mem_wvalid,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wlast,
    output logic                  mem_wready,
    output logic                  mem_bvalid,
    input  logic                  mem_bready,
    output logic                  err_pulse,
    output logic                  busy
);

    localparam int unsigned IDX_LO = BEAT_OFFSET_BITS;
    localparam int unsigned IDX_HI = MEM_ADDR_WIDTH + BEAT_OFFSET_BITS - 1;

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;

    rdState_t   rdState_q, rdState_d;
    idx_t       rdIdx_q, rdIdx_d;
    logic [7:0] rdLen_q, rdLen_d;
    logic [7:0] rdCnt_q, rdCnt_d;
    logic [3:0] waitCnt_q, waitCnt_d;

    wrState_t   wrState_q, wrState_d;
    idx_t       wrIdx_q, wrIdx_d;
    logic [7:0] wrLen_q, wrLen_d;
    logic [7:0] wrCnt_q, wrCnt_d;

    logic       err_q, err_d;

    logic                  ramRe;
    idx_t                  ramRaddr;
    logic                  ramWe;
    logic [DATA_WIDTH-1:0] ramRdata;

    logic arFire, rFire, awFire, wFire, bFire;
    logic wCountDone, wEnd;

    logic unusedAddrBits;
    assign unusedAddrBits = ^{mem_araddr[IDX_LO-1:0], mem_araddr[ADDR_WIDTH-1:IDX_HI+1],
                              mem_awaddr[IDX_LO-1:0], mem_awaddr[ADDR_WIDTH-1:IDX_HI+1]};

    // Every output is forced low while reset is asserted, not just after the reset edge.
    assign mem_arready = rst_n && (rdState_q == R_IDLE);
    assign mem_rvalid  = rst_n && (rdState_q == R_BURST);
    assign mem_rlast   = mem_rvalid && (rdCnt_q == rdLen_q);
    assign mem_rdata   = mem_rvalid ? ramRdata : '0;
    assign mem_awready = rst_n && (wrState_q == W_IDLE);
    assign mem_wready  = rst_n && (wrState_q == W_DATA);
    assign mem_bvalid  = rst_n && (wrState_q == W_RESP);
    assign err_pulse   = rst_n && err_q;
    assign busy        = rst_n && ((rdState_q != R_IDLE) || (wrState_q != W_IDLE));

    assign arFire     = mem_arvalid && mem_arready;
    assign rFire      = mem_rvalid && mem_rready;
    assign awFire     = mem_awvalid && mem_awready;
    assign wFire      = mem_wvalid && mem_wready;
    assign bFire      = mem_bvalid && mem_bready;
    assign wCountDone = (wrCnt_q == wrLen_q);
    assign wEnd       = mem_wlast || wCountDone;

    // The RAM read is launched on the last wait cycle and on every accepted non-final beat.
    always_comb begin
        rdState_d = rdState_q;
        rdIdx_d   = rdIdx_q;
        rdLen_d   = rdLen_q;
        rdCnt_d   = rdCnt_q;
        waitCnt_d = waitCnt_q;
        ramRe     = 1'b0;
        ramRaddr  = rdIdx_q;
        case (rdState_q)
            R_IDLE: begin
                if (arFire) begin
                    rdIdx_d   = mem_araddr[IDX_HI:IDX_LO];
                    rdLen_d   = mem_arlen;
                    rdCnt_d   = '0;
                    waitCnt_d = '0;
                    rdState_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (waitCnt_q == 4'(READ_LATENCY - 1)) begin
                    ramRe     = 1'b1;
                    rdState_d = R_BURST;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            R_BURST: begin
                if (rFire) begin
                    if (mem_rlast) begin
                        rdState_d = R_IDLE;
                    end else begin
                        rdIdx_d  = rdIdx_q + idx_t'(1);
                        rdCnt_d  = rdCnt_q + 8'd1;
                        ramRe    = 1'b1;
                        ramRaddr = rdIdx_q + idx_t'(1);
                    end
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_comb begin
        wrState_d = wrState_q;
        wrIdx_d   = wrIdx_q;
        wrLen_d   = wrLen_q;
        wrCnt_d   = wrCnt_q;
        ramWe     = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                if (awFire) begin
                    wrIdx_d   = mem_awaddr[IDX_HI:IDX_LO];
                    wrLen_d   = mem_awlen;
                    wrCnt_d   = '0;
                    wrState_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wFire) begin
                    ramWe   = 1'b1;
                    wrIdx_d = wrIdx_q + idx_t'(1);
                    wrCnt_d = wrCnt_q + 8'd1;
                    if (wEnd) begin
                        wrState_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bFire) begin
                    wrState_d = W_IDLE;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    // Illegal sizes are flagged but still served; a burst end is flagged when wlast and the count disagree.
    always_comb begin
        err_d = (arFire && (mem_arsize != SIZE_32B)) ||
                (awFire && (mem_awsize != SIZE_32B)) ||
                (wFire && wEnd && (mem_wlast != wCountDone));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdState_q <= R_IDLE;
            rdIdx_q   <= '0;
            rdLen_q   <= '0;
            rdCnt_q   <= '0;
            waitCnt_q <= '0;
            wrState_q <= W_IDLE;
            wrIdx_q   <= '0;
            wrLen_q   <= '0;
            wrCnt_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rdState_q <= rdState_d;
            rdIdx_q   <= rdIdx_d;
            rdLen_q   <= rdLen_d;
            rdCnt_q   <= rdCnt_d;
            waitCnt_q <= waitCnt_d;
            wrState_q <= wrState_d;
            wrIdx_q   <= wrIdx_d;
            wrLen_q   <= wrLen_d;
            wrCnt_q   <= wrCnt_d;
            err_q     <= err_d;
        end
    end

    gemm_mem_ram_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ramWe),
        .waddr_i(wrIdx_q),
        .wdata_i(mem_wdata),
        .re_i   (ramRe),
        .raddr_i(ramRaddr),
        .rdata_o(ramRdata)
    );

endmodule

// File: tb/tb_gemm_mem_responder.sv
// Directed bench for gemm_mem_responder with a queue-based transaction model checked every cycle.
module tb_gemm_mem_responder;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_arvalid;
    logic [31:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic [2:0]   mem_arsize;
    logic         mem_arready;
    logic         mem_rvalid;
    logic [255:0] mem_rdata;
    logic         mem_rlast;
    logic         mem_rready;
    logic         mem_awvalid;
    logic [31:0]  mem_awaddr;
    logic [7:0]   mem_awlen;
    logic [2:0]   mem_awsize;
    logic         mem_awready;
    logic         mem_wvalid;
    logic [255:0] mem_wdata;
    logic         mem_wlast;
    logic         mem_wready;
    logic         mem_bvalid;
    logic         mem_bready;
    logic         err_pulse;
    logic         busy;

    gemm_mem_responder #(
        .DATA_WIDTH(256), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
        .mem_arsize(mem_arsize), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .mem_rready(mem_rready),
        .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
        .mem_awsize(mem_awsize), .mem_awready(mem_awready),
        .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
        .mem_wready(mem_wready), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .err_pulse(err_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Model state: memory image, expected read beats, and outstanding write burst.
    logic [255:0] modelMem [1024];
    logic [255:0] rdQ [$];
    logic [255:0] gotBeats [$];
    logic [255:0] wrBuf [16];
    bit  monOn = 0;
    bit  rdBusy = 0, wrBusy = 0, wrResp = 0, errNext = 0, sawFirst = 1;
    int  cyc = 0, rdFirst = 0, arFireCyc = 0, firstGap = -1;
    int  wrIdx = 0, wrLen = 0, wrBeats = 0;
    int  errCount = 0, bvalidCycles = 0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic noteTimeout(input string name);
        vectors++;
        fails++;
        $display("[TB] FAIL %s: got timeout want handshake", name);
    endtask

    task automatic modelStep();
        logic expArready, expRvalid, expAwready, expWready, expBvalid, expErr, isFinal;
        int idx;
        cyc++;
        expErr  = errNext;
        errNext = 0;
        if (!rst_n) begin
            checkOutput("rst_arready", mem_arready, 0);
            checkOutput("rst_rvalid", mem_rvalid, 0);
            checkOutput("rst_rdata", mem_rdata, 0);
            checkOutput("rst_rlast", mem_rlast, 0);
            checkOutput("rst_awready", mem_awready, 0);
            checkOutput("rst_wready", mem_wready, 0);
            checkOutput("rst_bvalid", mem_bvalid, 0);
            checkOutput("rst_err", err_pulse, 0);
            checkOutput("rst_busy", busy, 0);
            rdQ.delete();
            rdBusy = 0; wrBusy = 0; wrResp = 0;
            return;
        end
        expArready = !rdBusy;
        expRvalid  = rdBusy && (cyc >= rdFirst) && (rdQ.size() > 0);
        expAwready = !wrBusy;
        expWready  = wrBusy && !wrResp;
        expBvalid  = wrBusy && wrResp;
        checkOutput("arready", mem_arready, expArready);
        checkOutput("rvalid", mem_rvalid, expRvalid);
        checkOutput("awready", mem_awready, expAwready);
        checkOutput("wready", mem_wready, expWready);
        checkOutput("bvalid", mem_bvalid, expBvalid);
        checkOutput("err_pulse", err_pulse, expErr);
        checkOutput("busy", busy, rdBusy || wrBusy);
        if (expRvalid) begin
            checkOutput("rdata", mem_rdata, rdQ[0]);
            checkOutput("rlast", mem_rlast, rdQ.size() == 1);
        end
        if (err_pulse) errCount++;
        if (mem_bvalid) bvalidCycles++;
        if (mem_rvalid && !sawFirst) begin
            firstGap = cyc - arFireCyc;
            sawFirst = 1;
        end
        if (expRvalid && mem_rready) begin
            gotBeats.push_back(mem_rdata);
            void'(rdQ.pop_front());
            if (rdQ.size() == 0) rdBusy = 0;
        end
        if (expArready && mem_arvalid) begin
            idx = int'(mem_araddr[14:5]);
            for (int i = 0; i <= int'(mem_arlen); i++) rdQ.push_back(modelMem[(idx + i) % 1024]);
            rdBusy    = 1;
            rdFirst   = cyc + LAT + 1;
            arFireCyc = cyc;
            sawFirst  = 0;
            if (mem_arsize != 3'b101) errNext = 1;
        end
        if (expBvalid && mem_bready) begin
            wrBusy = 0;
            wrResp = 0;
        end
        if (expWready && mem_wvalid) begin
            modelMem[wrIdx] = mem_wdata;
            wrIdx   = (wrIdx + 1) % 1024;
            wrBeats++;
            isFinal = (wrBeats == wrLen + 1);
            if (mem_wlast || isFinal) begin
                wrResp = 1;
                if (mem_wlast != isFinal) errNext = 1;
            end
        end
        if (expAwready && mem_awvalid) begin
            wrBusy  = 1;
            wrResp  = 0;
            wrIdx   = int'(mem_awaddr[14:5]);
            wrLen   = int'(mem_awlen);
            wrBeats = 0;
            if (mem_awsize != 3'b101) errNext = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (monOn) modelStep();
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input int nBeats, input int breadyDelay);
        int guard, seen;
        bit done;
        @(posedge clk); #1;
        mem_awvalid = 1; mem_awaddr = addr; mem_awlen = len; mem_awsize = size;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_awready && guard < 50);
        if (!mem_awready) noteTimeout("aw_handshake");
        @(posedge clk); #1;
        mem_awvalid = 0;
        for (int b = 0; b < nBeats; b++) begin
            mem_wvalid = 1; mem_wdata = wrBuf[b]; mem_wlast = (b == nBeats - 1);
            guard = 0;
            do begin @(negedge clk); guard++; end while (!mem_wready && guard < 50);
            if (!mem_wready) noteTimeout("w_handshake");
            @(posedge clk); #1;
        end
        mem_wvalid = 0; mem_wlast = 0; mem_wdata = '0;
        seen = 0; done = 0; guard = 0;
        while (!done && guard < 60) begin
            mem_bready = (seen >= breadyDelay);
            @(negedge clk);
            if (mem_bvalid) begin
                if (mem_bready) done = 1;
                else seen++;
            end
            guard++;
            @(posedge clk); #1;
        end
        mem_bready = 0;
        if (!done) noteTimeout("b_response");
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input bit stall);
        int guard, k;
        gotBeats.delete();
        @(posedge clk); #1;
        mem_arvalid = 1; mem_araddr = addr; mem_arlen = len; mem_arsize = size;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_arready && guard < 50);
        if (!mem_arready) noteTimeout("ar_handshake");
        @(posedge clk); #1;
        mem_arvalid = 0;
        k = 0; guard = 0;
        while (gotBeats.size() < int'(len) + 1 && guard < 200) begin
            mem_rready = stall ? (k % 3 == 0) : 1'b1;
            k++; guard++;
            @(posedge clk); #1;
        end
        mem_rready = 0;
        if (gotBeats.size() != int'(len) + 1) noteTimeout("r_beats");
    endtask

    initial begin
        int errBase, guard;
        for (int i = 0; i < 1024; i++) modelMem[i] = '0;
        rst_n = 0;
        mem_arvalid = 0; mem_araddr = '0; mem_arlen = '0; mem_arsize = 3'b101; mem_rready = 0;
        mem_awvalid = 0; mem_awaddr = '0; mem_awlen = '0; mem_awsize = 3'b101;
        mem_wvalid = 0; mem_wdata = '0; mem_wlast = 0; mem_bready = 0;
        repeat (3) @(posedge clk);
        monOn = 1;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checkOutput("reset_arready", mem_arready, 1);
        checkOutput("reset_busy", busy, 0);
        applyStimulus(2);

        // Single-beat preload and readback with latency measurement.
        wrBuf[0] = {32{8'hA5}};
        writeBurst(32'h80, 8'd0, 3'b101, 1, 0);
        readBurst(32'h80, 8'd0, 3'b101, 0);
        checkOutput("a5_beat", gotBeats[0], {32{8'hA5}});
        checkOutput("first_rvalid_gap", 256'(firstGap), 256'd3);

        // Four-beat burst with a held write response.
        for (int i = 0; i < 4; i++) wrBuf[i] = 256'(i + 1);
        bvalidCycles = 0;
        writeBurst(32'h0, 8'd3, 3'b101, 4, 3);
        checkOutput("bvalid_cycles", 256'(bvalidCycles), 256'd4);
        readBurst(32'h0, 8'd3, 3'b101, 0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rb4_beat%0d", i), gotBeats[i], 256'(i + 1));

        // Eight-beat burst read back with rready stalls.
        for (int i = 0; i < 8; i++) wrBuf[i] = 256'(32'h100 + i);
        writeBurst(32'h100, 8'd7, 3'b101, 8, 0);
        readBurst(32'h100, 8'd7, 3'b101, 1);
        checkOutput("stall_count", 256'(gotBeats.size()), 256'd8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("stall_beat%0d", i), gotBeats[i], 256'(32'h100 + i));

        // Write starting at the top word wraps to word 0.
        wrBuf[0] = 256'hDEAD0; wrBuf[1] = 256'hDEAD1;
        writeBurst(32'h7FE0, 8'd1, 3'b101, 2, 0);
        readBurst(32'h7FE0, 8'd1, 3'b101, 0);
        checkOutput("wrap_beat0", gotBeats[0], 256'hDEAD0);
        checkOutput("wrap_beat1", gotBeats[1], 256'hDEAD1);
        readBurst(32'h0, 8'd0, 3'b101, 0);
        checkOutput("wrap_word0", gotBeats[0], 256'hDEAD1);

        // Early wlast, then an illegal read size.
        wrBuf[0] = 256'h5A0; wrBuf[1] = 256'h5A1;
        errBase = errCount;
        writeBurst(32'h200, 8'd3, 3'b101, 2, 0);
        checkOutput("early_wlast_err", 256'(errCount - errBase), 256'd1);
        errBase = errCount;
        readBurst(32'h200, 8'd1, 3'b010, 0);
        checkOutput("bad_arsize_err", 256'(errCount - errBase), 256'd1);
        checkOutput("bad_arsize_beat0", gotBeats[0], 256'h5A0);
        checkOutput("bad_arsize_beat1", gotBeats[1], 256'h5A1);

        // Reset pulse while beat 3 of an 8-beat read is presented.
        gotBeats.delete();
        @(posedge clk); #1;
        mem_arvalid = 1; mem_araddr = 32'h100; mem_arlen = 8'd7; mem_arsize = 3'b101;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_arready && guard < 50);
        if (!mem_arready) noteTimeout("ar_handshake_rst");
        @(posedge clk); #1;
        mem_arvalid = 0; mem_rready = 1;
        guard = 0;
        while (gotBeats.size() < 3 && guard < 50) begin @(posedge clk); guard++; end
        if (gotBeats.size() < 3) noteTimeout("pre_reset_beats");
        #1;
        rst_n = 0; mem_rready = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checkOutput("post_rst_rvalid", mem_rvalid, 0);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_arready", mem_arready, 1);
        readBurst(32'h80, 8'd0, 3'b101, 0);
        checkOutput("post_rst_read", gotBeats[0], {32{8'hA5}});

        applyStimulus(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
